wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter: one buffered entry per requester, oldest-first grant,
// registered write port and decode hazard query. Optional macro WB_ARB_RR_EN: round-robin same-edge tie break.
module wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        pend1,
    output logic        pend2
);

    logic        a_full_r, a_age_r, b_full_r, b_age_r;
    logic [4:0]  a_addr_r, b_addr_r;
    logic [31:0] a_data_r, b_data_r;
    logic        we_r;
    logic [4:0]  wa_r;
    logic [31:0] wdata_r;

    logic a_grant_s, b_grant_s, tie_s, tie_b_wins_s;
    logic a_load_s, b_load_s, a_full_n_s, b_full_n_s, a_age_n_s, b_age_n_s;
    logic pend1_s, pend2_s;

`ifdef WB_ARB_RR_EN
    logic rr_b_r;

    // Round-robin pointer: after a tie grant, the other requester wins the next tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_b_r <= 1'b0;
        end else if (tie_s) begin
            rr_b_r <= a_grant_s;
        end else begin
            rr_b_r <= rr_b_r;
        end
    end

    assign tie_b_wins_s = rr_b_r;
`else
    assign tie_b_wins_s = 1'b0;
`endif

    // Grant selection: older entry first, same-age tie resolved by tie_b_wins_s.
    always_comb begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
        tie_s     = 1'b0;
        if (a_full_r && b_full_r) begin
            if (a_age_r) begin
                a_grant_s = 1'b1;
            end else if (b_age_r) begin
                b_grant_s = 1'b1;
            end else begin
                tie_s     = 1'b1;
                a_grant_s = !tie_b_wins_s;
                b_grant_s = tie_b_wins_s;
            end
        end else if (a_full_r) begin
            a_grant_s = 1'b1;
        end else if (b_full_r) begin
            b_grant_s = 1'b1;
        end else begin
            a_grant_s = 1'b0;
            b_grant_s = 1'b0;
        end
    end

    assign a_ready = !a_full_r || a_grant_s;
    assign b_ready = !b_full_r || b_grant_s;

    // Transfers to x0 complete the handshake but never occupy a buffer.
    assign a_load_s   = a_valid && a_ready && (a_addr != 5'd0);
    assign b_load_s   = b_valid && b_ready && (b_addr != 5'd0);
    assign a_full_n_s = a_load_s || (a_full_r && !a_grant_s);
    assign b_full_n_s = b_load_s || (b_full_r && !b_grant_s);

    // Age update: a newly loaded entry is younger than one that stays buffered.
    always_comb begin
        a_age_n_s = a_age_r;
        b_age_n_s = b_age_r;
        if (a_full_n_s && b_full_n_s) begin
            if (a_load_s && b_load_s) begin
                a_age_n_s = 1'b0;
                b_age_n_s = 1'b0;
            end else if (a_load_s) begin
                a_age_n_s = 1'b0;
                b_age_n_s = 1'b1;
            end else if (b_load_s) begin
                a_age_n_s = 1'b1;
                b_age_n_s = 1'b0;
            end else begin
                a_age_n_s = a_age_r;
                b_age_n_s = b_age_r;
            end
        end else begin
            a_age_n_s = 1'b0;
            b_age_n_s = 1'b0;
        end
    end

    // Buffer state and registered write-port drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_full_r <= 1'b0;
            b_full_r <= 1'b0;
            a_age_r  <= 1'b0;
            b_age_r  <= 1'b0;
            a_addr_r <= 5'd0;
            b_addr_r <= 5'd0;
            a_data_r <= 32'd0;
            b_data_r <= 32'd0;
            we_r     <= 1'b0;
            wa_r     <= 5'd0;
            wdata_r  <= 32'd0;
        end else begin
            a_full_r <= a_full_n_s;
            b_full_r <= b_full_n_s;
            a_age_r  <= a_age_n_s;
            b_age_r  <= b_age_n_s;
            if (a_load_s) begin
                a_addr_r <= a_addr;
                a_data_r <= a_data;
            end else begin
                a_addr_r <= a_addr_r;
                a_data_r <= a_data_r;
            end
            if (b_load_s) begin
                b_addr_r <= b_addr;
                b_data_r <= b_data;
            end else begin
                b_addr_r <= b_addr_r;
                b_data_r <= b_data_r;
            end
            we_r <= a_grant_s || b_grant_s;
            if (a_grant_s) begin
                wa_r    <= a_addr_r;
                wdata_r <= a_data_r;
            end else if (b_grant_s) begin
                wa_r    <= b_addr_r;
                wdata_r <= b_data_r;
            end else begin
                wa_r    <= wa_r;
                wdata_r <= wdata_r;
            end
        end
    end

    // Hazard query: a register is pending while buffered or being written this cycle.
    always_comb begin
        pend1_s = 1'b0;
        pend2_s = 1'b0;
        if (ra1 != 5'd0) begin
            pend1_s = (a_full_r && (a_addr_r == ra1)) || (b_full_r && (b_addr_r == ra1)) ||
                      (we_r && (wa_r == ra1));
        end else begin
            pend1_s = 1'b0;
        end
        if (ra2 != 5'd0) begin
            pend2_s = (a_full_r && (a_addr_r == ra2)) || (b_full_r && (b_addr_r == ra2)) ||
                      (we_r && (wa_r == ra2));
        end else begin
            pend2_s = 1'b0;
        end
    end

    assign we    = we_r;
    assign wa    = wa_r;
    assign wdata = wdata_r;
    assign pend1 = pend1_s;
    assign pend2 = pend2_s;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; tie expectations follow WB_ARB_RR_EN.
module tb_wb_arbiter;

    logic        clk, reset;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, wa, ra1, ra2;
    logic [31:0] a_data, b_data, wdata;
    logic        we, pend1, pend2;
    int          vectors = 0;
    int          miscompares = 0;

    wb_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we(we), .wa(wa), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .pend1(pend1), .pend2(pend2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; b_valid = 1'b0;
        a_addr = 5'd0; b_addr = 5'd0; a_data = 32'd0; b_data = 32'd0;
    endtask

    task automatic test_reset();
        idle(); ra1 = 5'd5; ra2 = 5'd0;
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %0b exp 0", we); end
        vectors++; if (wa !== 5'd0) begin miscompares++; $display("FAIL reset_wa got %0d exp 0", wa); end
        vectors++; if (wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", wdata); end
        vectors++; if ({a_ready, b_ready} !== 2'b11) begin miscompares++; $display("FAIL reset_ready got %b exp 11", {a_ready, b_ready}); end
        vectors++; if ({pend1, pend2} !== 2'b00) begin miscompares++; $display("FAIL reset_pend got %b exp 00", {pend1, pend2}); end
        ra1 = 5'd0;
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234; ra1 = 5'd5;
        tick();
        idle();
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL aonly_e1_we got %0b exp 0", we); end
        vectors++; if (pend1 !== 1'b1) begin miscompares++; $display("FAIL aonly_pend got %0b exp 1", pend1); end
        tick();
        vectors++; if ({we, wa, wdata} !== {1'b1, 5'd5, 32'h1234}) begin miscompares++; $display("FAIL aonly_write got we=%0b wa=%0d wdata=%h exp 1/5/1234", we, wa, wdata); end
        tick();
        vectors++; if ({we, wa} !== {1'b0, 5'd5}) begin miscompares++; $display("FAIL aonly_e3 got we=%0b wa=%0d exp 0/5", we, wa); end
        ra1 = 5'd0;
    endtask

    task automatic test_tie();
        logic [31:0] first_s, second_s;
        for (int t = 0; t < 2; t++) begin
            first_s = 32'hA; second_s = 32'hB;
`ifdef WB_ARB_RR_EN
            if (t == 1) begin first_s = 32'hB; second_s = 32'hA; end
`endif
            a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hA;
            b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB;
            tick();
            idle();
            vectors++; if ({a_ready, b_ready} !== ((first_s == 32'hA) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL tie%0d_ready got %b", t, {a_ready, b_ready}); end
            tick();
            vectors++; if ({we, wa, wdata} !== {1'b1, 5'd7, first_s}) begin miscompares++; $display("FAIL tie%0d_first got we=%0b wa=%0d wdata=%h exp 1/7/%h", t, we, wa, wdata, first_s); end
            tick();
            vectors++; if ({we, wa, wdata} !== {1'b1, 5'd7, second_s}) begin miscompares++; $display("FAIL tie%0d_second got we=%0b wa=%0d wdata=%h exp 1/7/%h", t, we, wa, wdata, second_s); end
            tick();
            vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL tie%0d_idle got we=%0b exp 0", t, we); end
        end
    endtask

    task automatic test_age();
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h33;
        tick();
        idle();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAA;
        tick();
        idle();
        vectors++; if ({we, wa, wdata} !== {1'b1, 5'd3, 32'h33}) begin miscompares++; $display("FAIL age_first got we=%0b wa=%0d wdata=%h exp 1/3/33", we, wa, wdata); end
        tick();
        vectors++; if ({we, wa, wdata} !== {1'b1, 5'd3, 32'hAA}) begin miscompares++; $display("FAIL age_second got we=%0b wa=%0d wdata=%h exp 1/3/aa", we, wa, wdata); end
        tick();
        vectors++; if ({we, wdata} !== {1'b0, 32'hAA}) begin miscompares++; $display("FAIL age_final got we=%0b wdata=%h exp 0/aa", we, wdata); end
    endtask

    task automatic test_back_to_back();
        // A wins the tie, refills immediately; the waiting B entry must go next.
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        tick();
        b_valid = 1'b0; a_addr = 5'd4; a_data = 32'h44;
        tick();
        idle();
        vectors++; if ({we, wa} !== {1'b1, 5'd1}) begin miscompares++; $display("FAIL b2b_w1 got we=%0b wa=%0d exp 1/1", we, wa); end
        vectors++; if ({a_ready, b_ready} !== 2'b01) begin miscompares++; $display("FAIL b2b_ready got %b exp 01", {a_ready, b_ready}); end
        tick();
        vectors++; if ({we, wa, wdata} !== {1'b1, 5'd2, 32'h22}) begin miscompares++; $display("FAIL b2b_w2 got we=%0b wa=%0d wdata=%h exp 1/2/22", we, wa, wdata); end
        tick();
        vectors++; if ({we, wa, wdata} !== {1'b1, 5'd4, 32'h44}) begin miscompares++; $display("FAIL b2b_w3 got we=%0b wa=%0d wdata=%h exp 1/4/44", we, wa, wdata); end
        tick();
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got we=%0b exp 0", we); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 3; i++) begin
            a_valid = 1'b1; a_addr = 5'(i + 16); a_data = 32'(i * 256);
            vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready%0d got %0b exp 1", i, a_ready); end
            tick();
            if (i > 1) begin
                vectors++; if ({we, wa} !== {1'b1, 5'(i + 15)}) begin miscompares++; $display("FAIL stream_w%0d got we=%0b wa=%0d exp 1/%0d", i - 1, we, wa, i + 15); end
            end
        end
        idle();
        tick();
        vectors++; if ({we, wa, wdata} !== {1'b1, 5'd19, 32'd768}) begin miscompares++; $display("FAIL stream_w3 got we=%0b wa=%0d wdata=%0d exp 1/19/768", we, wa, wdata); end
        tick();
    endtask

    task automatic test_addr0();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF; ra1 = 5'd0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL addr0_ready%0d got %0b exp 1", i, a_ready); end
            tick();
            vectors++; if ({we, pend1} !== 2'b00) begin miscompares++; $display("FAIL addr0_we_pend%0d got %b exp 00", i, {we, pend1}); end
        end
        idle();
        tick();
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL addr0_tail got we=%0b exp 0", we); end
    endtask

    task automatic test_hazard();
        b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hCAFE; ra1 = 5'd10; ra2 = 5'd11;
        tick();
        idle();
        vectors++; if ({we, pend1, pend2} !== 3'b010) begin miscompares++; $display("FAIL hazard_buf got we/p1/p2=%b exp 010", {we, pend1, pend2}); end
        tick();
        vectors++; if ({we, wa, pend1, pend2} !== {1'b1, 5'd10, 2'b10}) begin miscompares++; $display("FAIL hazard_wr got we=%0b wa=%0d p1=%0b p2=%0b exp 1/10/1/0", we, wa, pend1, pend2); end
        tick();
        vectors++; if ({we, pend1, pend2} !== 3'b000) begin miscompares++; $display("FAIL hazard_clr got we/p1/p2=%b exp 000", {we, pend1, pend2}); end
        ra1 = 5'd0; ra2 = 5'd0;
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h88;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
        tick();
        a_addr = 5'd12; a_data = 32'hC;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        ra1 = 5'd8; ra2 = 5'd9;
        vectors++; if ({we, a_ready, b_ready} !== 3'b011) begin miscompares++; $display("FAIL rstmid got we/ar/br=%b exp 011", {we, a_ready, b_ready}); end
        vectors++; if ({pend1, pend2} !== 2'b00) begin miscompares++; $display("FAIL rstmid_pend got %b exp 00", {pend1, pend2}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL rstmid_nowrite%0d got we=%0b wa=%0d exp 0", i, we, wa); end
        end
        ra1 = 5'd0; ra2 = 5'd0;
    endtask

    initial begin
        reset = 1'b1; ra1 = 5'd0; ra2 = 5'd0;
        idle();
        test_reset();
        test_a_only();
        test_tie();
        test_age();
        test_back_to_back();
        test_stream();
        test_addr0();
        test_hazard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
